// File: rtl/alu_pkg.sv
// Opcode and FSM state definitions shared by the digit-serial ALU and its slice.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Only add/sub produce carry and overflow; everything else reports 0.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice; the serial ALU reuses it once per digit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, the caller sequences it.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carryin,
    input  logic [2:0]       control,
    output logic [DIGIT-1:0] out,
    output logic             carryout
);

    logic [DIGIT:0] sum;

    // Slice function: sub is A + ~B + carryin, carry chained by the caller.
    always_comb begin
        sum      = '0;
        out      = '0;
        carryout = 1'b0;
        case (control)
            OP_PASSB: out = b;
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, carryin};
                out      = sum[DIGIT-1:0];
                carryout = sum[DIGIT];
            end
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, carryin};
                out      = sum[DIGIT-1:0];
                carryout = sum[DIGIT];
            end
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial WIDTH-bit ALU: one DIGIT-bit slice iterated WIDTH/DIGIT times, with flags.
// Latency: WIDTH/DIGIT cycles from accept to out_valid.
// Backpressure: result and flags hold in DONE until out_ready; no new accept until back in IDLE.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carryout
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_alu: WIDTH must be a multiple of DIGIT");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    step_q;
    logic [DIGIT-1:0] dig_out;
    logic             dig_cout;
    logic [WIDTH-1:0] res_nxt;
    logic             accept;
    logic             last_step;
    logic             a_msb, bmod_msb;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_sh[DIGIT-1:0]),
        .b        (b_sh[DIGIT-1:0]),
        .carryin  (carry_q),
        .control  (op_q),
        .out      (dig_out),
        .carryout (dig_cout)
    );

    // Slice output enters from the MSB end so the first digit lands at the bottom after NSTEP shifts.
    if (NSTEP == 1) begin : g_one_step
        assign res_nxt = dig_out;
    end else begin : g_multi_step
        assign res_nxt = {dig_out, result[WIDTH-1:DIGIT]};
    end

    assign accept    = in_valid & in_ready;
    assign last_step = (state == S_RUN) && (step_q == LAST);
    // On the last step the low digit of the shifters holds the operand MSBs.
    assign a_msb     = a_sh[DIGIT-1];
    assign bmod_msb  = b_sh[DIGIT-1] ^ (op_q == OP_SUB);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: accept in IDLE, count digits in RUN, wait for consumer in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)             state_nxt = S_RUN;
            S_RUN:   if (step_q == LAST)       state_nxt = S_DONE;
            S_DONE:  if (out_ready)            state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath: capture on accept, shift one digit per RUN cycle, register flags on the last digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            step_q   <= '0;
            result   <= '0;
            negative <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carryout <= 1'b0;
        end else if (accept) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            op_q    <= control;
            carry_q <= control[0];
            step_q  <= '0;
        end else if (state == S_RUN) begin
            a_sh    <= a_sh >> DIGIT;
            b_sh    <= b_sh >> DIGIT;
            result  <= res_nxt;
            carry_q <= dig_cout;
            if (!last_step) begin
                step_q <= step_q + CW'(1);
            end else begin
                negative <= res_nxt[WIDTH-1];
                zero     <= (res_nxt == '0);
                overflow <= op_is_arith(op_q) & (a_msb == bmod_msb) & (dig_out[DIGIT-1] != a_msb);
                carryout <= op_is_arith(op_q) & dig_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: an 8-bit-digit instance and a full-width (1-step) instance.
// Latency: checks accept-to-out_valid against the digit count of each instance.
// Backpressure: holds out_ready low in DONE and checks stability and ignored inputs.
module tb_serial_alu;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        n, z, v, c;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [63:0] a1, b1, res1;
    logic [2:0]  ctl1;
    logic        n1, z1, v1, c1;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [63:0] a2, b2, res2;
    logic [2:0]  ctl2;
    logic        n2, z2, v2, c2;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen1 = 0, post1 = 0, seen2 = 0, post2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_alu #(.WIDTH(64), .DIGIT(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_in(a1), .b_in(b1), .control(ctl1), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(res1), .negative(n1), .zero(z1), .overflow(v1), .carryout(c1)
    );

    serial_alu #(.WIDTH(64), .DIGIT(64)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a2), .b_in(b2), .control(ctl2), .out_valid(out_valid2), .out_ready(out_ready2),
        .result(res2), .negative(n2), .zero(z2), .overflow(v2), .carryout(c2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input logic [63:0] r,
                           input logic n, input logic z, input logic v, input logic c);
        chk({tag, ".result"},   r,      e.res);
        chk({tag, ".negative"}, 64'(n), 64'(e.n));
        chk({tag, ".zero"},     64'(z), 64'(e.z));
        chk({tag, ".overflow"}, 64'(v), 64'(e.v));
        chk({tag, ".carryout"}, 64'(c), 64'(e.c));
    endtask

    // Drive one operation, wait (bounded) for acceptance, then push the expected response.
    task automatic issue(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op, input logic [63:0] r,
                         input logic n, input logic z, input logic v, input logic c);
        exp_t e;
        bit   rdy;
        int   k;
        int   acc;
        @(posedge clk); #1;
        if (sel == 1) begin a1 = a; b1 = b; ctl1 = op; in_valid1 = 1'b1; end
        else          begin a2 = a; b2 = b; ctl2 = op; in_valid2 = 1'b1; end
        rdy = 1'b0;
        k   = 0;
        acc = 0;
        while (!rdy && k < 200) begin
            @(negedge clk);
            rdy = (sel == 1) ? in_ready1 : in_ready2;
            acc = cyc + 1;
            @(posedge clk);
            k++;
        end
        #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 64'(rdy), 64'd1);
        end else begin
            e.res = r; e.n = n; e.z = z; e.v = v; e.c = c;
            e.acc = acc;
            e.lat = (sel == 1) ? 8 : 1;
            if (sel == 1) q1.push_back(e);
            else          q2.push_back(e);
        end
    endtask

    // Monitor for the 8-bit-digit instance.
    always @(negedge clk) begin
        if (post1) begin
            chk("dut1.in_ready_after_handshake", 64'(in_ready1), 64'd1);
            post1 <= 1'b0;
        end
        if (!reset && out_valid1) begin
            if (q1.size() == 0) begin
                chk("dut1.unexpected_out_valid", 64'(out_valid1), 64'd0);
            end else begin
                if (!seen1) chk("dut1.latency", 64'(cyc - q1[0].acc), 64'(q1[0].lat));
                seen1 <= 1'b1;
                cmp_out("dut1", q1[0], res1, n1, z1, v1, c1);
                chk("dut1.in_ready_in_done", 64'(in_ready1), 64'd0);
                if (out_ready1) begin
                    void'(q1.pop_front());
                    seen1 <= 1'b0;
                    post1 <= 1'b1;
                end
            end
        end
    end

    // Monitor for the full-width instance.
    always @(negedge clk) begin
        if (post2) begin
            chk("dut2.in_ready_after_handshake", 64'(in_ready2), 64'd1);
            post2 <= 1'b0;
        end
        if (!reset && out_valid2) begin
            if (q2.size() == 0) begin
                chk("dut2.unexpected_out_valid", 64'(out_valid2), 64'd0);
            end else begin
                if (!seen2) chk("dut2.latency", 64'(cyc - q2[0].acc), 64'(q2[0].lat));
                seen2 <= 1'b1;
                cmp_out("dut2", q2[0], res2, n2, z2, v2, c2);
                chk("dut2.in_ready_in_done", 64'(in_ready2), 64'd0);
                if (out_ready2) begin
                    void'(q2.pop_front());
                    seen2 <= 1'b0;
                    post2 <= 1'b1;
                end
            end
        end
    end

    initial begin
        int k;
        reset = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; ctl1 = '0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; ctl2 = '0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid1", 64'(out_valid1), 64'd0);
        chk("rst.result1",    res1,            64'd0);
        chk("rst.flags1",     64'({n1, z1, v1, c1}), 64'd0);
        chk("rst.out_valid2", 64'(out_valid2), 64'd0);
        chk("rst.result2",    res2,            64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.in_ready1", 64'(in_ready1), 64'd1);
        chk("rst.in_ready2", 64'(in_ready2), 64'd1);

        // Add with carry through every digit, and carry across one digit boundary.
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(1, 64'h0000_0000_0000_00FF, 64'd1, OP_ADD, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        // Subtraction: borrow and signed overflow.
        issue(1, 64'd5, 64'd7, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1, 64'h8000_0000_0000_0000, 64'd1, OP_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        // Logic ops and pass-B.
        issue(1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_AND,
              64'hF000_F000_F000_F000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_OR,
              64'hFFF0_FFF0_FFF0_FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_XOR,
              64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_PASSB,
              64'hFF00_FF00_FF00_FF00, 1'b1, 1'b0, 1'b0, 1'b0);
        // Undefined opcodes yield zero.
        issue(1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b111, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(1, 64'h1234, 64'h5678, 3'b001, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold DONE, poke in_valid with junk, then release.
        issue(1, 64'd1, 64'd1, OP_ADD, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready1 = 1'b0;
        k = 0;
        while (!out_valid1 && k < 50) begin @(negedge clk); k++; end
        chk("bp.out_valid_reached", 64'(out_valid1), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid1 = 1'b1; a1 = 64'd99; b1 = 64'd99; ctl1 = OP_ADD;
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        issue(1, 64'd10, 64'd3, OP_SUB, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of RUN (step 3), then a clean add.
        issue(1, 64'h1111, 64'd1, OP_ADD, 64'h1112, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        q1.delete();
        @(negedge clk);
        chk("midrst.out_valid", 64'(out_valid1), 64'd0);
        chk("midrst.result",    res1,            64'd0);
        chk("midrst.in_ready",  64'(in_ready1),  64'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst.in_ready_after_release", 64'(in_ready1), 64'd1);
        chk("midrst.out_valid_after_release", 64'(out_valid1), 64'd0);
        issue(1, 64'd2, 64'd3, OP_ADD, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full-width digit: single-cycle operation.
        issue(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(2, 64'd5, 64'd7, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, OP_XOR,
              64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);

        k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < 200) begin @(negedge clk); k++; end
        chk("drain.pending", 64'(q1.size() + q2.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
